// File: rtl/program_counter.sv
// Instruction-address register for the pocket-calculator CPU, updated on the falling clock edge.
// Optional WRAP output (increment wrap-around pulse) is enabled by defining PC_WRAP_FLAG_EN.
module program_counter #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] POP_OFFSET  = WIDTH'(2)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             BRA,
    input  logic             STACK_POP,
    input  logic             FACT,
    input  logic [WIDTH-1:0] IN,
`ifdef PC_WRAP_FLAG_EN
    output logic             WRAP,
`endif
    output logic [WIDTH-1:0] OUT
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             incr;

    // Requests only count when EN is high; branch outranks pop, pop outranks hold.
    always_comb begin
        pc_d = pc_q + WIDTH'(1);
        incr = 1'b1;
        if (EN && BRA) begin
            pc_d = IN;
            incr = 1'b0;
        end else if (EN && STACK_POP) begin
            pc_d = IN + POP_OFFSET;
            incr = 1'b0;
        end else if (EN && FACT) begin
            pc_d = pc_q;
            incr = 1'b0;
        end
    end

    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign OUT = pc_q;

`ifdef PC_WRAP_FLAG_EN
    logic wrap_q, wrap_d;

    // Only a plain increment from all-ones wraps; loads landing on zero do not.
    assign wrap_d = incr && (pc_q == '1);

    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign WRAP = wrap_q;
`else
    logic unused_incr;
    assign unused_incr = incr;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table, corner sequences and a random phase,
// all checked through an expected-value queue. Covers WRAP when PC_WRAP_FLAG_EN is defined.
module tb_program_counter;

    logic        CLK;
    logic        RESET;
    logic        EN;
    logic        BRA;
    logic        STACK_POP;
    logic        FACT;
    logic [15:0] IN;
    logic [15:0] OUT;
`ifdef PC_WRAP_FLAG_EN
    logic        WRAP;
`endif

    program_counter #(
        .WIDTH      (16),
        .RESET_VALUE(16'h0000),
        .POP_OFFSET (16'h0002)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .BRA      (BRA),
        .STACK_POP(STACK_POP),
        .FACT     (FACT),
        .IN       (IN),
`ifdef PC_WRAP_FLAG_EN
        .WRAP     (WRAP),
`endif
        .OUT      (OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] pc;
        logic        wrap;
    } exp_t;

    typedef struct {
        logic        en;
        logic        bra;
        logic        pop;
        logic        fact;
        logic [15:0] din;
        logic [15:0] exp_pc;
        logic        exp_wrap;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[15];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] mdl_pc;
    logic        mdl_wrap;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic check_wrap(input string name, input logic [15:0] exp);
`ifdef PC_WRAP_FLAG_EN
        check(name, {15'd0, WRAP}, exp);
`else
        if (exp[0] === 1'bx) $display("unreachable");
`endif
    endtask

    // Drive one request ahead of the falling edge, queue its expected result,
    // then compare the DUT shortly after that edge.
    task automatic step(input string name, input logic en, input logic bra, input logic pop,
                        input logic fact, input logic [15:0] din, input exp_t exp);
        exp_t got_exp;
        @(posedge CLK);
        EN        = en;
        BRA       = bra;
        STACK_POP = pop;
        FACT      = fact;
        IN        = din;
        sb_q.push_back(exp);
        @(negedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got 0x%04h", name, OUT);
        end else begin
            got_exp = sb_q.pop_front();
            check(name, OUT, got_exp.pc);
            check_wrap({name, "_wrap"}, {15'd0, got_exp.wrap});
        end
        mdl_pc   = exp.pc;
        mdl_wrap = exp.wrap;
    endtask

    // Independent reference of the next-state rule, used for the random phase.
    function automatic exp_t model(input logic [15:0] pc, input logic en, input logic bra,
                                   input logic pop, input logic fact, input logic [15:0] din);
        exp_t r;
        r.wrap = 1'b0;
        if (en && bra)       r.pc = din;
        else if (en && pop)  r.pc = din + 16'd2;
        else if (en && fact) r.pc = pc;
        else begin
            r.pc   = pc + 16'd1;
            r.wrap = (pc == 16'hFFFF);
        end
        return r;
    endfunction

    initial begin
        //            en    bra   pop   fact  din        exp_pc     exp_wrap
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0001, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0002, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h6AB3, 16'h6AB3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h87AB, 16'h87AD, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h87AB, 16'h87AE, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0010, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0010, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0010, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0010, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 16'h0011, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1000, 16'h1000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0};

        EN = 1'b0; BRA = 1'b0; STACK_POP = 1'b0; FACT = 1'b0; IN = 16'h0000;
        RESET = 1'b1;

        // Reset takes effect before any clock edge has occurred.
        #3 RESET = 1'b0;
        #1;
        check("reset_async", OUT, 16'h0000);
        check_wrap("reset_async_wrap", 16'h0000);
        EN = 1'b1; BRA = 1'b1; IN = 16'hBEEF;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_hold_edges", OUT, 16'h0000);
        @(negedge CLK);
        #1;
        check("reset_hold_negedge", OUT, 16'h0000);
        EN = 1'b0; BRA = 1'b0;
        RESET = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].bra, vecs[i].pop, vecs[i].fact,
                 vecs[i].din, '{pc: vecs[i].exp_pc, wrap: vecs[i].exp_wrap});
        end

        // Mid-run reset with a pending branch request.
        @(posedge CLK);
        EN = 1'b1; BRA = 1'b1; IN = 16'h4444;
        #2 RESET = 1'b0;
        #1;
        check("reset_midrun_async", OUT, 16'h0000);
        @(negedge CLK);
        #1;
        check("reset_midrun_over_req", OUT, 16'h0000);
        check_wrap("reset_midrun_wrap", 16'h0000);
        RESET = 1'b1;
        step("post_reset_first", 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, '{pc: 16'h0001, wrap: 1'b0});
        step("post_reset_second", 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, '{pc: 16'h0002, wrap: 1'b0});

        // Branch to all-ones then a plain increment wraps and pulses WRAP once.
        step("wrap_bra", 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, '{pc: 16'hFFFF, wrap: 1'b0});
        step("wrap_inc", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, '{pc: 16'h0000, wrap: 1'b1});
        step("wrap_clear", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, '{pc: 16'h0001, wrap: 1'b0});

        for (int k = 0; k < 300; k++) begin
            logic        en, bra, pop, fact;
            logic [15:0] din;
            exp_t        e;
            en   = $urandom_range(0, 3) != 0;
            bra  = $urandom_range(0, 4) == 0;
            pop  = $urandom_range(0, 4) == 0;
            fact = $urandom_range(0, 2) == 0;
            din  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1))
                                               : 16'($urandom);
            e = model(mdl_pc, en, bra, pop, fact, din);
            step($sformatf("rand%0d", k), en, bra, pop, fact, din, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
